// File: rtl/pipe_skid_stage_reg_pkg.sv
// Shared types for the handshaked pipeline stage register.
// Occupancy encoding plus a helper to derive it from entry valids.
package pipe_skid_stage_reg_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic occ_e occ_of(
    input logic head_valid,
    input logic skid_valid
  );
    logic [1:0] sum;
    sum = {1'b0, head_valid} + {1'b0, skid_valid};
    return occ_e'(sum);
  endfunction

endpackage

// File: rtl/pipe_skid_stage_reg_entry.sv
// One pipeline entry: WIDTH data bits plus a valid flag.
// Priority: reset, then clear (to CLEAR_VALUE), then load.
module pipe_entry_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  // entry state: reset > clear > load > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= RESET_VALUE;
      valid <= 1'b0;
    end else if (clear) begin
      q     <= CLEAR_VALUE;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_stage_reg.sv
// Handshaked pipeline stage register with optional 2-entry skid.
// Supports flush (bubble insertion) and a global busywait freeze.
module pipe_skid_stage_reg
  import pipe_skid_stage_reg_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
  parameter int               SKID_EN      = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BUSYWAIT,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [1:0]       OCCUPANCY
);

  logic             head_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] head_data;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] head_d;
  logic             head_load;
  logic             head_clr;
  logic             skid_load;
  logic             skid_clr;
  logic             in_fire;
  logic             out_fire;
  logic             room;
  occ_e             occ;

  // with skid, readiness depends only on registered state
  assign room = (SKID_EN != 0) ? ~skid_valid
                               : (~head_valid | OUT_READY);

  assign IN_READY = room & ~BUSYWAIT & ~FLUSH & ~RESET;
  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = head_valid & OUT_READY & ~BUSYWAIT;

  assign OUT_VALID = head_valid;
  assign OUT_DATA  = head_data;
  assign OCCUPANCY = occ;

  // occupancy state derived from the two entry valids
  always_comb begin
    occ = occ_of(head_valid, skid_valid);
  end

  // entry control: flush first, then handshake moves per state
  always_comb begin
    head_load = 1'b0;
    head_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    head_d    = IN_DATA;
    if (FLUSH) begin
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (occ)
        OCC_EMPTY: head_load = in_fire;
        OCC_ONE: begin
          unique case (1'b1)
            in_fire & out_fire:  head_load = 1'b1;
            in_fire & ~out_fire: skid_load = 1'b1;
            ~in_fire & out_fire: head_clr  = 1'b1;
            default: ;
          endcase
        end
        OCC_FULL: begin
          if (out_fire) begin
            head_load = 1'b1;
            head_d    = skid_data;
            skid_clr  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pipe_entry_reg #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE),
    .CLEAR_VALUE(BUBBLE_VALUE)
  ) u_head (
    .clk  (CLK),
    .rst  (RESET),
    .load (head_load),
    .clear(head_clr),
    .d    (head_d),
    .q    (head_data),
    .valid(head_valid)
  );

  if (SKID_EN != 0) begin : g_skid
    pipe_entry_reg #(
      .WIDTH      (WIDTH),
      .RESET_VALUE(BUBBLE_VALUE),
      .CLEAR_VALUE(BUBBLE_VALUE)
    ) u_skid (
      .clk  (CLK),
      .rst  (RESET),
      .load (skid_load),
      .clear(skid_clr),
      .d    (IN_DATA),
      .q    (skid_data),
      .valid(skid_valid)
    );
  end else begin : g_noskid
    logic unused_skid;
    assign skid_data   = BUBBLE_VALUE;
    assign skid_valid  = 1'b0;
    assign unused_skid = skid_load | skid_clr;
  end

endmodule

// File: tb/tb_pipe_skid_stage_reg.sv
// Bench: skid and no-skid stages share stimulus; a queue model
// checks both every cycle, plus literal spot checks.
module tb_pipe_skid_stage_reg;

  localparam logic [31:0] RV  = 32'hFFFFFFFC;
  localparam logic [31:0] BUB = 32'h0;

  logic        clk = 0;
  logic        rst, busy, fl, iv, ordy;
  logic [31:0] d;
  logic [1:0]  ir, ov;
  logic [31:0] od [2];
  logic [1:0]  oc [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mq [2][$];
  logic [31:0] idle [2];
  bit          known = 0;

  always #5 clk = ~clk;

  pipe_skid_stage_reg #(
    .WIDTH(32), .RESET_VALUE(RV),
    .BUBBLE_VALUE(BUB), .SKID_EN(1)
  ) dut_a (
    .CLK(clk), .RESET(rst), .BUSYWAIT(busy),
    .FLUSH(fl), .IN_VALID(iv), .IN_READY(ir[0]),
    .IN_DATA(d), .OUT_VALID(ov[0]),
    .OUT_READY(ordy), .OUT_DATA(od[0]),
    .OCCUPANCY(oc[0])
  );

  pipe_skid_stage_reg #(
    .WIDTH(32), .RESET_VALUE(RV),
    .BUBBLE_VALUE(BUB), .SKID_EN(0)
  ) dut_b (
    .CLK(clk), .RESET(rst), .BUSYWAIT(busy),
    .FLUSH(fl), .IN_VALID(iv), .IN_READY(ir[1]),
    .IN_DATA(d), .OUT_VALID(ov[1]),
    .OUT_READY(ordy), .OUT_DATA(od[1]),
    .OCCUPANCY(oc[1])
  );

  task automatic chk(string nm, int i,
                     logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d got %h want %h",
               nm, i, got, exp);
    end
  endtask

  function automatic logic exp_rdy(int i);
    logic room;
    room = (i == 0) ? (mq[i].size() < 2)
                    : (mq[i].size() == 0 || ordy);
    return room & ~rst & ~fl & ~busy;
  endfunction

  // model compare, then model advance for the coming edge
  always @(negedge clk) begin
    logic r [2];
    if (known) begin
      for (int i = 0; i < 2; i++) begin
        logic ev;
        ev = mq[i].size() > 0;
        chk("out_valid", i, {31'b0, ov[i]}, {31'b0, ev});
        chk("out_data", i, od[i], ev ? mq[i][0] : idle[i]);
        chk("occupancy", i, {30'b0, oc[i]},
            32'(mq[i].size()));
        chk("in_ready", i, {31'b0, ir[i]},
            {31'b0, exp_rdy(i)});
      end
    end
    for (int i = 0; i < 2; i++) r[i] = exp_rdy(i);
    if (rst) begin
      known = 1;
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        idle[i] = RV;
      end
    end else if (known && fl) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        idle[i] = BUB;
      end
    end else if (known && !busy) begin
      for (int i = 0; i < 2; i++) begin
        if (mq[i].size() > 0 && ordy) begin
          void'(mq[i].pop_front());
          if (mq[i].size() == 0) idle[i] = BUB;
        end
        if (iv && r[i]) mq[i].push_back(d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] dd, logic o);
    iv   = v;
    d    = dd;
    ordy = o;
  endtask

  initial begin
    rst = 1; busy = 0; fl = 0; iv = 0; ordy = 0; d = 0;
    // reset
    @(negedge clk);
    chk("rst_in_ready", 0, {31'b0, ir[0]}, 32'd0);
    chk("rst_in_ready", 1, {31'b0, ir[1]}, 32'd0);
    tick();
    rst = 0;
    #1;
    chk("rst_data", 0, od[0], 32'hFFFFFFFC);
    chk("rst_valid", 0, {31'b0, ov[0]}, 32'd0);
    chk("rst_occ", 0, {30'b0, oc[0]}, 32'd0);
    // streaming
    drive(1, 23, 1);
    tick();
    chk("lat1_data", 0, od[0], 32'd23);
    chk("lat1_valid", 0, {31'b0, ov[0]}, 32'd1);
    d = 45; tick(); chk("stream", 0, od[0], 32'd45);
    d = 33; tick(); chk("stream", 0, od[0], 32'd33);
    d = 56; tick(); chk("stream", 0, od[0], 32'd56);
    chk("stream_occ", 0, {30'b0, oc[0]}, 32'd1);
    iv = 0; tick();
    chk("drain_data", 0, od[0], 32'd0);
    // skid fill and drain
    drive(1, 15, 0); tick();
    d = 25; tick();
    iv = 0; #1;
    chk("full_occ", 0, {30'b0, oc[0]}, 32'd2);
    chk("full_rdy", 0, {31'b0, ir[0]}, 32'd0);
    chk("full_head", 0, od[0], 32'd15);
    ordy = 1; tick();
    chk("drain1", 0, od[0], 32'd25);
    chk("drain1_occ", 0, {30'b0, oc[0]}, 32'd1);
    tick();
    chk("drain2_occ", 0, {30'b0, oc[0]}, 32'd0);
    // busywait freeze while full
    drive(1, 15, 0); tick();
    d = 25; tick();
    iv = 0; busy = 1; ordy = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("busy_data", 0, od[0], 32'd15);
      chk("busy_occ", 0, {30'b0, oc[0]}, 32'd2);
      chk("busy_rdy", 0, {31'b0, ir[0]}, 32'd0);
    end
    // flush under busywait with a pending input
    drive(1, 99, 0); fl = 1; #1;
    chk("flush_rdy", 0, {31'b0, ir[0]}, 32'd0);
    tick();
    fl = 0; busy = 0; drive(0, 0, 1);
    #1;
    chk("flush_valid", 0, {31'b0, ov[0]}, 32'd0);
    chk("flush_data", 0, od[0], 32'd0);
    chk("flush_occ", 0, {30'b0, oc[0]}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no99", 0, {31'b0, ov[0]}, 32'd0);
    end
    // no-skid pass-through ready
    rst = 1; tick(); rst = 0;
    drive(1, 43, 0); tick();
    d = 55; #1;
    chk("ns_rdy0", 1, {31'b0, ir[1]}, 32'd0);
    tick();
    chk("ns_hold", 1, od[1], 32'd43);
    ordy = 1; #1;
    chk("ns_rdy1", 1, {31'b0, ir[1]}, 32'd1);
    tick();
    chk("ns_pass", 1, od[1], 32'd55);
    chk("ns_pass_v", 1, {31'b0, ov[1]}, 32'd1);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      iv   = $urandom_range(0, 3) != 0;
      d    = $urandom;
      ordy = $urandom_range(0, 2) != 0;
      busy = $urandom_range(0, 9) == 0;
      fl   = $urandom_range(0, 31) == 0;
      rst  = $urandom_range(0, 199) == 0;
      tick();
    end
    rst = 0; fl = 0; busy = 0; iv = 0; ordy = 1;
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
